// File: rtl/glyph_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// glyph_rom_arbiter_if
// Bundles the four requester ports and the shared glyph ROM connection of
// glyph_rom_arbiter.
//   req[3:0]        request per port (0 fir, 1 sec, 2 disp_u, 3 disp_d)
//   addr_*[7:0]     per-port {glyph[7:4], row[3:0]}, stable while req high
//   rom_addr[7:0]   address to the shared synchronous-read ROM
//   rom_data[15:0]  ROM row data, valid one cycle after rom_addr
//   gnt[3:0]        one-hot grant pulse, aligned with rom_addr
//   rd_valid[3:0]   one-hot pulse one cycle after gnt, tags rom_data
//   char_*[15:0]    per-port held row data, bit 15 = leftmost pixel
// master: requesters + ROM side; slave: the arbiter.
// ---------------------------------------------------------------------------
interface glyph_rom_arbiter_if;
   logic [3:0]  req;
   logic [7:0]  addr_fir;
   logic [7:0]  addr_sec;
   logic [7:0]  addr_disp_u;
   logic [7:0]  addr_disp_d;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [3:0]  gnt;
   logic [3:0]  rd_valid;
   logic [15:0] char_fir;
   logic [15:0] char_sec;
   logic [15:0] char_disp_u;
   logic [15:0] char_disp_d;

   modport master (
      output req, addr_fir, addr_sec, addr_disp_u, addr_disp_d, rom_data,
      input  rom_addr, gnt, rd_valid,
      input  char_fir, char_sec, char_disp_u, char_disp_d
   );

   modport slave (
      input  req, addr_fir, addr_sec, addr_disp_u, addr_disp_d, rom_data,
      output rom_addr, gnt, rd_valid,
      output char_fir, char_sec, char_disp_u, char_disp_d
   );
endinterface

// File: rtl/glyph_rom_arbiter.sv
// ---------------------------------------------------------------------------
// glyph_rom_arbiter
// Shares one single-port synchronous glyph ROM between four row fetchers
// with a two-stage pipeline:
//   S1: round-robin arbitration -> registered gnt / rom_addr
//   S2: registered rd_valid tag; the tagged port's char register captures
//       rom_data on the following edge.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    glyph_rom_arbiter_if.slave (requests, addresses, ROM, char rows)
// ---------------------------------------------------------------------------
module glyph_rom_arbiter (
   input  logic               clk,
   input  logic               rst_n,
   glyph_rom_arbiter_if.slave bus
);

   logic [3:0]  gnt_q, gnt_d;
   logic [7:0]  rom_addr_q, rom_addr_d;
   logic [1:0]  last_q, last_d;
   logic [3:0]  rd_valid_q;
   logic [15:0] char_q [4];

   logic [7:0]  port_addr [4];
   logic [3:0]  eligible;
   logic [1:0]  idx;
   logic        found;

   always_comb begin
      port_addr[0] = bus.addr_fir;
      port_addr[1] = bus.addr_sec;
      port_addr[2] = bus.addr_disp_u;
      port_addr[3] = bus.addr_disp_d;
   end

   // Search order last+1, last+2, last+3, last (i = 4 wraps to last itself).
   // Masking with gnt_q keeps a just-granted port out of the next round.
   always_comb begin
      eligible   = bus.req & ~gnt_q;
      gnt_d      = '0;
      last_d     = last_q;
      rom_addr_d = rom_addr_q;
      found      = 1'b0;
      idx        = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         idx = last_q + i[1:0];
         if (!found && eligible[idx]) begin
            found      = 1'b1;
            gnt_d[idx] = 1'b1;
            last_d     = idx;
            rom_addr_d = port_addr[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q      <= '0;
         rom_addr_q <= '0;
         last_q     <= 2'd3;
         rd_valid_q <= '0;
         for (int unsigned k = 0; k < 4; k++) begin
            char_q[k] <= '0;
         end
      end else begin
         gnt_q      <= gnt_d;
         rom_addr_q <= rom_addr_d;
         last_q     <= last_d;
         // An issued grant always completes: the tag follows gnt regardless
         // of what req does in the meantime.
         rd_valid_q <= gnt_q;
         for (int unsigned k = 0; k < 4; k++) begin
            if (rd_valid_q[k]) begin
               char_q[k] <= bus.rom_data;
            end
         end
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.rom_addr    = rom_addr_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.char_fir    = char_q[0];
   assign bus.char_sec    = char_q[1];
   assign bus.char_disp_u = char_q[2];
   assign bus.char_disp_d = char_q[3];

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_glyph_rom_arbiter
// Directed bench for glyph_rom_arbiter with a behavioural synchronous ROM.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_glyph_rom_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] rom_q = '0;
   int checks = 0;
   int errors = 0;

   glyph_rom_arbiter_if bus ();

   glyph_rom_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_lookup(input logic [7:0] a);
      case (a)
         8'h50:   rom_lookup = 16'hFFFF;
         8'h53:   rom_lookup = 16'hE000;
         8'h59:   rom_lookup = 16'h000F;
         8'h5A:   rom_lookup = 16'h0F0F;
         default: rom_lookup = {a, ~a};
      endcase
   endfunction

   always @(posedge clk) rom_q <= rom_lookup(bus.rom_addr);
   assign bus.rom_data = rom_q;

   task automatic do_reset;
      bus.req = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      bus.req = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0000) begin
         errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt);
      end
      checks++;
      if (bus.rd_valid !== 4'b0000) begin
         errors++; $display("FAIL reset_rd_valid: got %b want 0000", bus.rd_valid);
      end
      checks++;
      if (bus.rom_addr !== 8'h00) begin
         errors++; $display("FAIL reset_rom_addr: got %h want 00", bus.rom_addr);
      end
      checks++;
      if ({bus.char_fir, bus.char_sec, bus.char_disp_u, bus.char_disp_d} !== 64'h0) begin
         errors++;
         $display("FAIL reset_chars: got %h %h %h %h want all 0000",
                  bus.char_fir, bus.char_sec, bus.char_disp_u, bus.char_disp_d);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_read;
      do_reset();
      bus.req = 4'b0001;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0001 || bus.rom_addr !== 8'h50) begin
         errors++;
         $display("FAIL single_gnt: got gnt=%b addr=%h want 0001/50", bus.gnt, bus.rom_addr);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 4'b0001 || bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL single_rd_valid: got rd_valid=%b gnt=%b want 0001/0000",
                  bus.rd_valid, bus.gnt);
      end
      @(negedge clk);
      checks++;
      if (bus.char_fir !== 16'hFFFF || bus.rd_valid !== 4'b0000) begin
         errors++;
         $display("FAIL single_char: got char_fir=%h rd_valid=%b want FFFF/0000",
                  bus.char_fir, bus.rd_valid);
      end
   endtask

   // Continues from test_single_read: last points at port 0.
   task automatic test_idle_hold;
      bus.req = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (bus.gnt !== 4'b0000 || bus.rd_valid !== 4'b0000 || bus.char_fir !== 16'hFFFF) begin
            errors++;
            $display("FAIL idle_cycle%0d: got gnt=%b rd_valid=%b char_fir=%h want 0000/0000/FFFF",
                     i, bus.gnt, bus.rd_valid, bus.char_fir);
         end
      end
      bus.req = 4'b1111;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.rom_addr !== 8'h53) begin
         errors++;
         $display("FAIL idle_next_grant: got gnt=%b addr=%h want 0010/53", bus.gnt, bus.rom_addr);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_rotation;
      logic [3:0] exp_g [5];
      logic [7:0] exp_a [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_a = '{8'h50, 8'h53, 8'h5A, 8'h59, 8'h50};
      do_reset();
      bus.req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         checks++;
         if (bus.gnt !== exp_g[j] || bus.rom_addr !== exp_a[j]) begin
            errors++;
            $display("FAIL rotation_gnt%0d: got gnt=%b addr=%h want %b/%h",
                     j, bus.gnt, bus.rom_addr, exp_g[j], exp_a[j]);
         end
         if (j > 0) begin
            checks++;
            if (bus.rd_valid !== exp_g[j-1]) begin
               errors++;
               $display("FAIL rotation_tag%0d: got %b want %b", j, bus.rd_valid, exp_g[j-1]);
            end
         end
         checks++;
         if ($isunknown({bus.gnt, bus.rd_valid, bus.rom_addr, bus.char_fir,
                         bus.char_sec, bus.char_disp_u, bus.char_disp_d})) begin
            errors++;
            $display("FAIL rotation_no_x%0d: got X on outputs want known", j);
         end
      end
      bus.req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      do_reset();
      bus.req = 4'b1010;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.rom_addr !== 8'h53) begin
         errors++;
         $display("FAIL b2b_gnt_sec: got gnt=%b addr=%h want 0010/53", bus.gnt, bus.rom_addr);
      end
      bus.req = 4'b1000;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b1000 || bus.rom_addr !== 8'h59 || bus.rd_valid !== 4'b0010) begin
         errors++;
         $display("FAIL b2b_gnt_disp_d: got gnt=%b addr=%h rd_valid=%b want 1000/59/0010",
                  bus.gnt, bus.rom_addr, bus.rd_valid);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 4'b1000 || bus.char_sec !== 16'hE000 || bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_sec_data: got rd_valid=%b char_sec=%h gnt=%b want 1000/E000/0000",
                  bus.rd_valid, bus.char_sec, bus.gnt);
      end
      @(negedge clk);
      checks++;
      if (bus.char_disp_d !== 16'h000F || bus.char_sec !== 16'hE000 || bus.char_fir !== 16'h0000) begin
         errors++;
         $display("FAIL b2b_disp_d_data: got disp_d=%h sec=%h fir=%h want 000F/E000/0000",
                  bus.char_disp_d, bus.char_sec, bus.char_fir);
      end
   endtask

   task automatic test_reset_mid_read;
      do_reset();
      bus.req = 4'b0100;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.rom_addr !== 8'h5A) begin
         errors++;
         $display("FAIL midrst_gnt: got gnt=%b addr=%h want 0100/5A", bus.gnt, bus.rom_addr);
      end
      rst_n = 1'b0;
      bus.req = 4'b0000;
      #1;
      checks++;
      if (bus.gnt !== 4'b0000 || bus.rd_valid !== 4'b0000 || bus.rom_addr !== 8'h00) begin
         errors++;
         $display("FAIL midrst_async: got gnt=%b rd_valid=%b addr=%h want 0000/0000/00",
                  bus.gnt, bus.rd_valid, bus.rom_addr);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rd_valid !== 4'b0000 || bus.char_disp_u !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_no_tag%0d: got rd_valid=%b char_disp_u=%h want 0000/0000",
                     i, bus.rd_valid, bus.char_disp_u);
         end
      end
      bus.req = 4'b1111;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++; $display("FAIL midrst_first_grant: got %b want 0001", bus.gnt);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_fairness;
      logic [3:0] pat [8];
      logic [3:0] exp_g [8];
      pat   = '{4'b0101, 4'b0101, 4'b0001, 4'b0101, 4'b0101, 4'b0001, 4'b0101, 4'b0101};
      exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0100, 4'b0001};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         bus.req = pat[k];
         @(negedge clk);
         checks++;
         if (bus.gnt !== exp_g[k]) begin
            errors++;
            $display("FAIL fairness_gnt%0d: got %b want %b", k, bus.gnt, exp_g[k]);
         end
      end
      bus.req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      bus.req         = '0;
      bus.addr_fir    = 8'h50;
      bus.addr_sec    = 8'h53;
      bus.addr_disp_u = 8'h5A;
      bus.addr_disp_d = 8'h59;
      test_reset();
      test_single_read();
      test_idle_hold();
      test_rotation();
      test_back_to_back();
      test_reset_mid_read();
      test_fairness();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/glyph_rom_arbiter.md
GLYPH_ROM_ARBITER -- requirements
Module: glyph_rom_arbiter

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port `req`, input, 4 bits: request per port; bit0 fir, bit1 sec, bit2 disp_u, bit3 disp_d.
REQ-004 SHALL have ports `addr_fir`, `addr_sec`, `addr_disp_u`, `addr_disp_d`, input, 8 bits each: {glyph[7:4], row[3:0]}; stable while that port's req is high.
REQ-005 SHALL have port `rom_addr`, output, 8 bits: address to the shared single-port glyph ROM.
REQ-006 SHALL have port `rom_data`, input, 16 bits: ROM row data; synchronous read, valid 1 cycle after rom_addr.
REQ-007 SHALL have port `gnt`, output, 4 bits: one-hot grant pulse, same cycle rom_addr carries that port's address.
REQ-008 SHALL have port `rd_valid`, output, 4 bits: one-hot pulse, 1 cycle after gnt, marks rom_data belonging to that port.
REQ-009 SHALL have ports `char_fir`, `char_sec`, `char_disp_u`, `char_disp_d`, output, 16 bits each: per-port held row data, bit 15 = leftmost pixel.

Function
REQ-010 SHALL be a two-stage pipeline: S1 arbitrate (registered gnt/rom_addr), S2 capture (registered rd_valid, port tag).
REQ-011 SHALL issue at most one grant per cycle, with back-to-back grants to different ports in consecutive cycles.
REQ-012 SHALL define eligible = req & ~gnt (a port granted this cycle is excluded from the next arbitration).
REQ-013 SHALL arbitrate round-robin: search eligible bits starting at (last+1) mod 4 upward, wrapping 3->0; winner becomes last.
REQ-014 SHALL update last only on an actual grant; no eligible request -> gnt=0000, rom_addr holds previous value, last unchanged.
REQ-015 SHALL latency: req sampled high at edge N -> gnt and rom_addr at N (visible cycle N..N+1), rd_valid at N+1, char_x updated at N+2 edge.
REQ-016 SHALL on rd_valid[k] load char_k <= rom_data; other char registers hold.
REQ-017 SHALL keep char_x unchanged indefinitely when not re-read (display holds last row).
REQ-018 SHALL require the requester to drop req within 1 cycle after seeing gnt, or accept another grant on its next round-robin turn.
REQ-019 SHALL grant a continuously requesting port again only after every other eligible port (no starvation; max wait 3 grants).
REQ-020 SHALL ignore req changes on a port between its gnt and rd_valid (in-flight read always completes).
REQ-021 SHALL produce no X on outputs for any req pattern, including 1111 and 0000.

Reset
REQ-022 SHALL on rst_n low immediately force gnt=0000, rd_valid=0000, rom_addr=0x00, all char_x=0x0000, last=3 (port 0 highest priority after reset).
REQ-023 SHALL discard any in-flight read on reset mid-operation; no rd_valid pulse after release for a grant issued before reset.
REQ-024 SHALL start arbitrating on the first rising edge with rst_n high.

Verification
REQ-025 SHALL verify single read: after reset, req=0001, addr_fir=0x50, ROM glyph5 row0=0xFFFF -> gnt=0001, rom_addr=0x50, next cycle rd_valid=0001, char_fir=0xFFFF.
REQ-026 SHALL verify all-request rotation: req=1111 held -> gnt sequence 0001,0010,0100,1000,0001 with the masking of REQ-012 on consecutive cycles.
REQ-027 SHALL verify pipelined back-to-back reads: addr_sec=0x53 (0xE000), addr_disp_d=0x59 (0x000F), req=1010 -> gnt 0010 then 1000; char_sec=0xE000, char_disp_d=0x000F; rd_valid tags match.
REQ-028 SHALL verify idle hold: req=0000 for 10 cycles after REQ-025 -> gnt=0000, rd_valid=0000, char_fir stays 0xFFFF, last unchanged (next req=1111 grants 0010 first).
REQ-029 SHALL verify reset mid-read: assert rst_n low in the cycle gnt=0100 -> no rd_valid after release, char_disp_u=0x0000, first grant after release for req=1111 is 0001.
REQ-030 SHALL verify fairness under held req: req[0] held high, req[2] toggled -> port 0 never granted twice in a row while port 2 eligible.
